// File: rtl/piso_serializer.sv
// Purpose : parallel-in/serial-out stage; takes a WIDTH-bit word on a valid/ready
//           handshake and emits it LSB first, one bit per clock, with an optional
//           even-parity bit after the data bits (enabled by defining PARITY_EN).
// Latency : bit0 appears on `out` the cycle after the accept edge; a frame is FRAME cycles.
// Backpr. : load_ready is high only in IDLE or on the last bit of a frame. Upstream
//           holds load_valid/load_data until accepted. Words can be sent back to back.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   load_data  parallel word, captured on the accept edge
//   load_valid upstream has a word on load_data
//   load_ready serializer can accept a word this cycle
//   out        serial bit, drives the downstream shift register input
//   out_valid  out carries a valid bit this cycle
//   busy       high while a frame is being shifted
//   done       one-cycle pulse with the final bit of a frame (the parity bit when enabled)
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [FRAME-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic [FRAME-1:0] frame_word;
  logic             last_bit;
  logic             accept;

  // The parity bit sits above the data so it falls out of the shift register
  // after the last data bit. It is computed from the captured word, so it
  // cannot change while the frame is being sent.
`ifdef PARITY_EN
  assign frame_word = {^load_data, load_data};
`else
  assign frame_word = load_data;
`endif

  assign last_bit   = (state == SHIFT) && (count == LAST_CNT);
  // Ready on the last bit as well as in IDLE lets a new word follow with no gap.
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= frame_word;
      count <= '0;
    end else if (last_bit) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else if (state == SHIFT) begin
      shreg <= {1'b0, shreg[FRAME-1:1]};
      count <= count + CNT_W'(1);
    end
  end

  // All outputs decode straight from the state flops. Reset clears them at once.
  assign busy      = (state == SHIFT);
  assign out_valid = busy;
  assign out       = busy & shreg[0];
  assign done      = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
  localparam int WIDTH = 4;
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = WIDTH;
  localparam bit PAR   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  exp_t             sb[$];
  int               tests = 0;
  int               fails = 0;
  int               done_cnt = 0;
  int               valid_cnt = 0;
  logic [FRAME-1:0] ds = '0;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_data (load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Downstream right-shift register fed by the serial output.
  always @(posedge clk) if (out_valid) ds <= {out, ds[FRAME-1:1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      exp_t e;
      e.b = w[i];
      e.d = (!PAR) && (i == WIDTH - 1);
      sb.push_back(e);
    end
    if (PAR) begin
      exp_t e;
      e.b = ^w;
      e.d = 1'b1;
      sb.push_back(e);
    end
  endtask

  // One clock: record a handshake, advance, then check outputs against the scoreboard.
  task automatic step();
    if (load_valid && load_ready) push_frame(load_data);
    @(posedge clk);
    #1;
    chk("busy_eq_valid", busy, out_valid);
    if (out_valid) begin
      valid_cnt++;
      if (done) done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_bit", out, e.b);
        chk("done_flag", done, e.d);
      end
    end else begin
      chk("gap_pending_bits", sb.size(), 0);
      chk("idle_out", out, 0);
      chk("idle_done", done, 0);
      chk("idle_ready", load_ready, 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_bound", sb.size(), 0);
    step();
    chk("drain_idle", out_valid, 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    load_data  = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 4'hF;

    // Reset held for two cycles with a word offered: nothing is accepted.
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_ready", load_ready, 1);
      chk("rst_out", out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    load_valid = 1'b0;
    rst        = 1'b1;
    repeat (2) step();

    // Single word 0001, then check what the downstream register holds.
    valid_cnt = 0;
    send(4'b0001);
    drain();
    chk("single_valid_cycles", valid_cnt, FRAME);
    chk("downstream_word", ds[WIDTH-1:0], 4'b0001);

    // Back to back: A then 5 held valid until taken.
    done_cnt  = 0;
    valid_cnt = 0;
    send(4'hA);
    load_data  = 4'h5;
    load_valid = 1'b1;
    for (int i = 0; i < 20 && load_valid; i++) begin
      if (load_ready) begin
        step();
        load_valid = 1'b0;
      end else begin
        step();
      end
    end
    chk("b2b_taken", load_valid, 0);
    drain();
    chk("b2b_done_pulses", done_cnt, 2);
    chk("b2b_valid_cycles", valid_cnt, 2 * FRAME);

    // Word offered during the second bit of 3: held off until the last bit.
    send(4'h3);
    step();
    load_data  = 4'hF;
    load_valid = 1'b1;
    for (int i = 1; i < FRAME - 1; i++) begin
      chk("busy_load_not_ready", load_ready, 0);
      step();
    end
    chk("busy_load_ready_last", load_ready, 1);
    step();
    load_valid = 1'b0;
    drain();

    // Reset two bits into C: outputs clear at once, remaining bits are lost.
    done_cnt = 0;
    send(4'hC);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out", out, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", load_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) step();
    chk("midrst_no_done", done_cnt, 0);
    send(4'h6);
    drain();

    // Word 0111: data 1,1,1,0 plus parity 1 when enabled.
    valid_cnt = 0;
    done_cnt  = 0;
    send(4'b0111);
    drain();
    chk("p_valid_cycles", valid_cnt, FRAME);
    chk("p_done_pulses", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
